// File: rtl/fir_filter_s00_axi_slave.sv
// fir_filter_s00_axi_slave
// AXI4-Lite responder for the FIR filter S00_AXI control port. Holds four
// 32-bit control registers at byte offsets 0x0/0x4/0x8/0xC and exports them
// to the filter datapath as regs_o = {reg3, reg2, reg1, reg0}.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN     clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  write address, data and response channels
//   S_AXI_AR* / S_AXI_R*          read address and data channels
//   regs_o                        register file contents to the filter core
//
// Build option:
//   FIR_S00_AXI_WSTRB_EN  when defined, commits honour WSTRB per byte lane;
//                         otherwise every commit writes all 32 bits.
module fir_filter_s00_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_o
);

    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [3:0][C_S_AXI_DATA_WIDTH-1:0] regs;
    logic [1:0]                         aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]      wdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]      rdata_q;
    logic                               aw_hs, w_hs, ar_hs, commit;
    logic [1:0]                         c_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]      c_data;

    // ---------------- write channel ----------------
    assign S_AXI_AWREADY = ((w_state == W_IDLE) || (w_state == W_HAVE_DATA)) && S_AXI_ARESETN;
    assign S_AXI_WREADY  = ((w_state == W_IDLE) || (w_state == W_HAVE_ADDR)) && S_AXI_ARESETN;
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = 2'b00;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) w_state <= W_IDLE;
        else                w_state <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state;
        commit       = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit       = 1'b1;
                    w_state_next = W_RESP;
                end else if (aw_hs) begin
                    w_state_next = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: if (w_hs) begin
                commit       = 1'b1;
                w_state_next = W_RESP;
            end
            W_HAVE_DATA: if (aw_hs) begin
                commit       = 1'b1;
                w_state_next = W_RESP;
            end
            W_RESP: if (S_AXI_BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // A commit takes whichever half arrived earlier from the latch and the
    // other half straight off the bus.
    assign c_idx  = (w_state == W_HAVE_ADDR) ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign c_data = (w_state == W_HAVE_DATA) ? wdata_q  : S_AXI_WDATA;

`ifdef FIR_S00_AXI_WSTRB_EN
    logic [NBYTES-1:0]             wstrb_q;
    logic [NBYTES-1:0]             c_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] c_mask;

    assign c_strb = (w_state == W_HAVE_DATA) ? wstrb_q : S_AXI_WSTRB;

    always_comb begin
        c_mask = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            c_mask[8*b +: 8] = {8{c_strb[b]}};
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) wstrb_q <= '0;
        else if (w_hs)      wstrb_q <= S_AXI_WSTRB;
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^S_AXI_WSTRB;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_idx_q <= '0;
            wdata_q  <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs)  wdata_q  <= S_AXI_WDATA;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            regs <= '0;
        end else if (commit) begin
`ifdef FIR_S00_AXI_WSTRB_EN
            regs[c_idx] <= (regs[c_idx] & ~c_mask) | (c_data & c_mask);
`else
            regs[c_idx] <= c_data;
`endif
        end
    end

    assign regs_o = regs;

    // ---------------- read channel ----------------
    assign S_AXI_ARREADY = (r_state == R_IDLE) && S_AXI_ARESETN;
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata_q;

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_state <= R_IDLE;
        else                r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Sampling regs (not the commit result) gives a same-edge read the
    // pre-write value.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) rdata_q <= '0;
        else if (ar_hs)     rdata_q <= regs[S_AXI_ARADDR[3:2]];
    end

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_fir_filter_s00_axi_slave.sv
// Directed bench for fir_filter_s00_axi_slave: write/read round trips, AW/W
// ordering, B/R backpressure, byte strobes, same-edge collision and reset
// in the middle of a write.
module tb_fir_filter_s00_axi_slave;

    logic         aclk, aresetn;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] regs;

    int checks = 0;
    int errors = 0;

    fir_filter_s00_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .S_AXI_ACLK   (aclk),
        .S_AXI_ARESETN(aresetn),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .regs_o       (regs)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit aw_now, w_now, aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            tick();
            if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
            if (w_now)  begin wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        check("wr_handshake", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("wr_bvalid", bvalid, 1'b1);
        check("wr_bresp", bresp, 2'b00);
        tick();
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit ar_now, ar_done;
        int n;
        ar_done = 0; n = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!ar_done && n < 20) begin
            ar_now = arvalid && arready;
            tick();
            if (ar_now) begin arvalid = 1'b0; ar_done = 1; end
            n++;
        end
        check("rd_handshake", ar_done, 1'b1);
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        check("rd_rvalid", rvalid, 1'b1);
        check("rd_rresp", rresp, 2'b00);
        data = rdata;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] strb_exp;

        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '1; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;

        // reset state
        tick(); tick();
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_regs", regs, 128'h0);
        check("rst_rdata", rdata, 32'h0);
        aresetn = 1'b1;
        #1;
        check("post_rst_readies", {awready, wready, arready}, 3'b111);

        // sequential write/read
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check("seq_rdata", rd, 32'(i + 1));
        end
        check("seq_regs", regs, 128'h00000004_00000003_00000002_00000001);

        // AW first, W three cycles later
        awaddr = 4'h8; awvalid = 1'b1; bready = 1'b0;
        check("awfirst_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0; awaddr = 4'h0;
        tick(); tick();
        check("awfirst_wait", {bvalid, awready}, 2'b00);
        wdata = 32'hDEADBEEF; wvalid = 1'b1;
        check("awfirst_wready", wready, 1'b1);
        tick();
        wvalid = 1'b0; wdata = '0;
        check("awfirst_bvalid", bvalid, 1'b1);
        check("awfirst_reg2", regs[95:64], 32'hDEADBEEF);
        bready = 1'b1;
        tick();
        check("awfirst_bdone", bvalid, 1'b0);

        // W first, AW three cycles later
        axi_write(4'h8, 32'h0, 4'hF);
        wdata = 32'hDEADBEEF; wvalid = 1'b1; bready = 1'b0;
        check("wfirst_wready", wready, 1'b1);
        tick();
        wvalid = 1'b0; wdata = '0;
        tick(); tick();
        check("wfirst_wait", {bvalid, wready}, 2'b00);
        awaddr = 4'h8; awvalid = 1'b1;
        check("wfirst_awready", awready, 1'b1);
        tick();
        awvalid = 1'b0; awaddr = 4'h0;
        check("wfirst_bvalid", bvalid, 1'b1);
        check("wfirst_reg2", regs[95:64], 32'hDEADBEEF);
        bready = 1'b1;
        tick();

        // B backpressure, second write held off until the B handshake
        awaddr = 4'h4; wdata = 32'h11111111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awaddr = 4'h0; wdata = 32'h55;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid_held", bvalid, 1'b1);
            check("bp_blocked", {awready, wready}, 2'b00);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bp_bdone", bvalid, 1'b0);
        check("bp_second_ready", {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_second_bvalid", bvalid, 1'b1);
        check("bp_regs01", regs[63:0], 64'h11111111_00000055);
        tick();

        // R backpressure
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0; araddr = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("rbp_rvalid", rvalid, 1'b1);
            check("rbp_rdata", rdata, 32'h11111111);
            tick();
        end
        rready = 1'b1;
        tick();
        check("rbp_rdone", rvalid, 1'b0);

        // byte strobes
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
        axi_write(4'h4, 32'h12345678, 4'b0101);
`ifdef FIR_S00_AXI_WSTRB_EN
        strb_exp = 32'hFF34FF78;
`else
        strb_exp = 32'h12345678;
`endif
        axi_read(4'h4, rd);
        check("strb_reg1", rd, strb_exp);

        // same-edge read/write collision on reg3
        axi_write(4'hC, 32'hA, 4'hF);
        araddr = 4'hC; arvalid = 1'b1; rready = 1'b1;
        awaddr = 4'hC; wdata = 32'hB; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("coll_valids", {rvalid, bvalid}, 2'b11);
        check("coll_rdata", rdata, 32'hA);
        tick();
        axi_read(4'hC, rd);
        check("coll_reread", rd, 32'hB);

        // reset with a write half-accepted
        awaddr = 4'h4; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b1;
        tick();
        awvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check("mrst_readies", {awready, wready, arready}, 3'b000);
        tick();
        check("mrst_bvalid0", bvalid, 1'b0);
        tick();
        check("mrst_bvalid1", bvalid, 1'b0);
        check("mrst_regs", regs, 128'h0);
        aresetn = 1'b1;
        // a lone W must not pair with the discarded address
        wdata = 32'h99; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("mrst_discard", bvalid, 1'b0);
        awaddr = 4'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mrst_bvalid_after", bvalid, 1'b1);
        tick();
        axi_read(4'h4, rd);
        check("mrst_roundtrip", rd, 32'h99);
        axi_write(4'h8, 32'hCAFE0001, 4'hF);
        axi_read(4'h8, rd);
        check("mrst_roundtrip2", rd, 32'hCAFE0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
